// File: rtl/data_memory_pipelined.sv
// Data memory for the MEM stage: single-port RAM with a valid/ready request
// port, byte/half/word stores and extended loads, misalignment flagging,
// an RD_LAT-deep ordered response pipeline and a post-reset init sequencer.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_INIT | sequencer writes one word per cycle, requests refused
// ST_RUN  | requests accepted, one per cycle
module data_memory_pipelined #(
  parameter int ADDR_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int INIT_IDX = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [31:0]         mem [DEPTH];

  logic                accept;
  logic [ADDR_W-1:0]   idx;
  logic [1:0]          lane;
  logic                err;
  logic [31:0]         rd_shift;
  logic [31:0]         ld_data;
  logic [31:0]         wr_shift;
  logic [3:0]          wr_be;

  logic                pipe_v [RD_LAT];
  logic [31:0]         pipe_d [RD_LAT];
  logic                pipe_e [RD_LAT];

  // Upper address bits are deliberately dropped so accesses wrap.
  logic                unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign accept = req_valid & req_ready;
  assign idx    = req_addr[ADDR_W+1:2];
  assign lane   = req_addr[1:0];

  // Decode illegal size and misalignment; such requests never touch the array.
  always_comb begin
    err = 1'b0;
    case (req_size)
      2'b00:   err = 1'b0;
      2'b01:   err = lane[0];
      2'b10:   err = (lane != 2'b00);
      default: err = 1'b1;
    endcase
  end

  // Shift the addressed lanes down and extend to 32 bits.
  always_comb begin
    rd_shift = mem[idx] >> {lane, 3'b000};
    ld_data  = '0;
    case (req_size)
      2'b00:   ld_data = req_unsigned ? {24'h0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_data = req_unsigned ? {16'h0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
      2'b10:   ld_data = rd_shift;
      default: ld_data = '0;
    endcase
  end

  // Byte enables and lane-aligned store data; halves are aligned when err=0.
  always_comb begin
    wr_shift = req_wdata << {lane, 3'b000};
    wr_be    = 4'b0000;
    case (req_size)
      2'b00:   wr_be = 4'b0001 << lane;
      2'b01:   wr_be = 4'b0011 << lane;
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // Init sequencer and run-mode handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      cnt       <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state     <= ST_RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        default: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // Array writes: init fill, else lane-masked stores of legal requests.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= (INIT_IDX != 0) ? 32'(cnt) : 32'h0;
    end else if (accept && req_write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_shift[8*b +: 8];
      end
    end
  end

  // Ordered response pipeline; stage 0 captures the result at the accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
        pipe_e[i] <= 1'b0;
      end
    end else begin
      pipe_v[0] <= accept;
      pipe_d[0] <= (accept && !req_write && !err) ? ld_data : 32'h0;
      pipe_e[0] <= accept & err;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
        pipe_e[i] <= pipe_e[i-1];
      end
    end
  end

  assign rsp_valid = pipe_v[RD_LAT-1];
  assign rsp_rdata = pipe_d[RD_LAT-1];
  assign rsp_err   = pipe_e[RD_LAT-1];

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Directed bench: two instances (RD_LAT=3 and RD_LAT=4) share one request port.
module tb_data_memory_pipelined;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;

  logic        req_ready3, rsp_valid3, rsp_err3, init_done3;
  logic [31:0] rsp_rdata3;
  logic        req_ready4, rsp_valid4, rsp_err4, init_done4;
  logic [31:0] rsp_rdata4;

  int total = 0;
  int bad   = 0;
  int pulses4 = 0;
  logic watch4 = 1'b0;

  always #5 clk = ~clk;

  data_memory_pipelined #(.ADDR_W(8), .RD_LAT(3), .INIT_IDX(1)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .init_done(init_done3)
  );

  data_memory_pipelined #(.ADDR_W(8), .RD_LAT(4), .INIT_IDX(1)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready4),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid4),
    .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4), .init_done(init_done4)
  );

  always @(negedge clk) if (watch4 && rsp_valid4) pulses4++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (init_done3) begin
        n = i;
        break;
      end
    end
    chk({tag, "_init_cycles"}, n, 256);
    chk({tag, "_ready3"}, req_ready3, 1'b1);
    chk({tag, "_ready4"}, req_ready4, 1'b1);
    chk({tag, "_done4"}, init_done4, 1'b1);
  endtask

  // One request; response checked on the RD_LAT=3 instance, then RD_LAT=4.
  task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    int lat;
    lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_size = sz; req_unsigned = uns; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (rsp_valid3) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat3"}, lat, 3);
    chk({tag, "_data3"}, rsp_rdata3, exp_d);
    chk({tag, "_err3"}, rsp_err3, exp_e);
    @(negedge clk);
    chk({tag, "_valid4"}, rsp_valid4, 1'b1);
    chk({tag, "_data4"}, rsp_rdata4, exp_d);
  endtask

  initial begin
    int pulses;
    #2;
    chk("rst_ready", req_ready3, 1'b0);
    chk("rst_valid", rsp_valid3, 1'b0);
    chk("rst_rdata", rsp_rdata3, 32'h0);
    chk("rst_err", rsp_err3, 1'b0);
    chk("rst_done", init_done3, 1'b0);
    repeat (2) @(negedge clk);

    wait_init("t1");
    xact("t1_ld3fc", 1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0, 32'h000000FF, 1'b0);

    xact("t2_sw80", 1'b1, 32'h80, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0);
    xact("t2_sb81", 1'b1, 32'h81, 2'b00, 1'b0, 32'h000000AA, 32'h0, 1'b0);
    xact("t2_lw80", 1'b0, 32'h80, 2'b10, 1'b0, 32'h0, 32'h1122AA44, 1'b0);
    xact("t2_lbs81", 1'b0, 32'h81, 2'b00, 1'b0, 32'h0, 32'hFFFFFFAA, 1'b0);
    xact("t2_lbu81", 1'b0, 32'h81, 2'b00, 1'b1, 32'h0, 32'h000000AA, 1'b0);
    xact("t2_lhs80", 1'b0, 32'h80, 2'b01, 1'b0, 32'h0, 32'hFFFFAA44, 1'b0);
    xact("t2_lhu80", 1'b0, 32'h80, 2'b01, 1'b1, 32'h0, 32'h0000AA44, 1'b0);
    xact("t2_lhs82", 1'b0, 32'h82, 2'b01, 1'b0, 32'h0, 32'h00001122, 1'b0);
    xact("t2_sh82", 1'b1, 32'h82, 2'b01, 1'b0, 32'h1234BEEF, 32'h0, 1'b0);
    xact("t2_lw80b", 1'b0, 32'h80, 2'b10, 1'b0, 32'h0, 32'hBEEFAA44, 1'b0);
    xact("t2_lbu83", 1'b0, 32'h83, 2'b00, 1'b1, 32'h0, 32'h000000BE, 1'b0);

    // Back-to-back store then load of the same word.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
    req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_write = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (rsp_valid3) begin
        pulses++;
        if (pulses == 1) begin
          chk("t3_st_pos", n, 2);
          chk("t3_st_data", rsp_rdata3, 32'h0);
        end else begin
          chk("t3_ld_pos", n, 3);
          chk("t3_ld_data", rsp_rdata3, 32'hDEADBEEF);
        end
      end
      if (n == 3) chk("t3_st_valid4", rsp_valid4, 1'b1);
      if (n == 4) begin
        chk("t3_ld_valid4", rsp_valid4, 1'b1);
        chk("t3_ld_data4", rsp_rdata4, 32'hDEADBEEF);
      end
    end
    chk("t3_pulses", pulses, 2);

    xact("t4_lh13", 1'b0, 32'h13, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("t4_sw16", 1'b1, 32'h16, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("t4_lw14", 1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 32'h00000005, 1'b0);
    xact("t4_sz11ld", 1'b0, 32'h20, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("t4_sz11st", 1'b1, 32'h20, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("t4_lw20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h00000008, 1'b0);
    xact("t4_sb21", 1'b1, 32'h21, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);

    xact("t5_sw400", 1'b1, 32'h400, 2'b10, 1'b0, 32'h5A5A5A5A, 32'h0, 1'b0);
    xact("t5_lw000", 1'b0, 32'h000, 2'b10, 1'b0, 32'h0, 32'h5A5A5A5A, 1'b0);

    // Three loads in flight on the RD_LAT=4 instance, then reset.
    @(negedge clk);
    watch4 = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h3FC;
    req_size = 2'b10; req_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("t6_ready4", req_ready4, 1'b0);
    chk("t6_ready3", req_ready3, 1'b0);
    chk("t6_done4", init_done4, 1'b0);
    chk("t6_valid4", rsp_valid4, 1'b0);
    repeat (3) @(negedge clk);
    wait_init("t6");
    repeat (2) @(negedge clk);
    watch4 = 1'b0;
    chk("t6_pulses4", pulses4, 0);
    xact("t6_lw000", 1'b0, 32'h000, 2'b10, 1'b0, 32'h0, 32'h00000000, 1'b0);
    xact("t6_lw080", 1'b0, 32'h080, 2'b10, 1'b0, 32'h0, 32'h00000020, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
